mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of BUSY cycles without mem_ready before an access is abandoned.
REQ-002 SHALL have parameter CNTW, default 5, meaning the timeout counter width (2^CNTW > TIMEOUT).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low; sampled only on the rising clk edge.
REQ-005 Addr  input  16  byte address from execute.
REQ-006 WriteData  input  16  store data.
REQ-007 MemRead  input  1  current instruction is a load.
REQ-008 MemWrite  input  1  current instruction is a store.
REQ-009 Halt  input  1  current instruction is HALT.
REQ-010 mem_req  output  1  request to data memory; registered.
REQ-011 mem_wr  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-012 mem_addr  output  16  latched word-aligned address.
REQ-013 mem_wdata  output  16  latched store data.
REQ-014 mem_rdata  input  16  read data; valid only when mem_ready=1.
REQ-015 mem_ready  input  1  one-cycle completion pulse from memory.
REQ-016 MemOut  output  16  load result; drives the write-back select input 1.
REQ-017 Stall  output  1  holds the upstream pipeline; combinational.
REQ-018 Err  output  1  sticky error flag.
REQ-019 Halted  output  1  sticky; processor has stopped.

Function
REQ-020 The FSM SHALL have states IDLE, BUSY, DONE and ERR.
REQ-021 Valid access SHALL be: exactly one of MemRead/MemWrite set, Addr[0]=0, Err=0 and Halted=0.
REQ-022 In IDLE with a valid access, Stall SHALL be 1, and the next edge SHALL latch Addr, WriteData and MemWrite into mem_addr, mem_wdata and mem_wr, clear the counter, and enter BUSY.
REQ-023 mem_req SHALL be 1 in BUSY only.
REQ-024 In BUSY, Stall SHALL be 1, and the counter SHALL increment each cycle mem_ready=0.
REQ-025 In BUSY with mem_ready=1, the FSM SHALL enter DONE; if mem_wr=0, MemOut SHALL load mem_rdata on that edge.
REQ-026 mem_ready=1 on the same cycle the counter reaches TIMEOUT-1 SHALL count as completion (ready wins).
REQ-027 In BUSY, if the counter reaches TIMEOUT-1 with mem_ready=0, the FSM SHALL enter ERR and set Err; MemOut SHALL be unchanged.
REQ-028 DONE SHALL last exactly one cycle with Stall=0, then return to IDLE regardless of inputs, so that the same instruction is not re-issued.
REQ-029 Minimum load/store latency SHALL be 3 cycles (IDLE accept, BUSY with ready, DONE).
REQ-030 MemOut SHALL hold its value across stores, idle cycles and errors; only a completed read updates it.
REQ-031 In IDLE, MemRead=MemWrite=1 or (MemRead|MemWrite) with Addr[0]=1 SHALL set Err, enter ERR, issue no request, and hold Stall=0.
REQ-032 ERR SHALL be absorbing until reset, with Err=1, Stall=0, mem_req=0, and all inputs ignored.
REQ-033 mem_ready SHALL be ignored in IDLE, DONE and ERR.
REQ-034 In IDLE, Halt=1 with no access SHALL set Halted on the next edge.
REQ-035 Halt presented with an access SHALL set Halted on the DONE-to-IDLE transition.
REQ-036 Once Halted=1, no further request SHALL be issued and Stall SHALL be 0.
REQ-037 With no access and no Halt, Stall SHALL be 0 and the block SHALL remain idle.

Reset
REQ-038 rst=0 at a clock edge SHALL force IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, MemOut=0, Err=0, Halted=0 and counter=0, overriding any in-flight access.
REQ-039 With rst=0, Stall SHALL be 0.
REQ-040 After reset release, a late mem_ready SHALL be ignored.

Verification
REQ-041 Load: Addr=0x0010, MemRead=1; memory returns mem_rdata=0xBEEF with ready on the 2nd BUSY cycle -> Stall=1 for 3 cycles, mem_req=1 with mem_addr=0x0010, then DONE with Stall=0 and MemOut=0xBEEF.
REQ-042 Store: Addr=0x0020, WriteData=0x1234, MemWrite=1, ready on the 1st BUSY cycle -> mem_wr=1, mem_wdata=0x1234, and MemOut retains its prior value 0xBEEF.
REQ-043 Unaligned access: Addr=0x0021, MemRead=1 -> Err=1 next cycle, mem_req never asserted, Stall=0; a subsequent aligned load is ignored.
REQ-044 Timeout: load with mem_ready held 0 -> mem_req high for exactly 16 cycles, then Err=1, Stall=0. Also: ready exactly on the 16th cycle -> DONE, not ERR.
REQ-045 Reset mid-BUSY: rst=0 on the 3rd BUSY cycle -> next cycle all outputs are reset values, and a mem_ready pulse after release leaves MemOut=0.
REQ-046 Halt with load: Halt=1 and MemRead=1 -> the load completes, and Halted=1 on the cycle after DONE; a later access issues no mem_req.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory request per load/store, stalls the pipeline
// until completion, and tracks sticky error and halt conditions.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Halt,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] MemOut,
  output logic        Stall,
  output logic        Err,
  output logic        Halted
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CNTW-1:0] cnt;
  logic            halt_pend;
  logic            stall_raw;
  logic            any_access;
  logic            bad_access;
  logic            valid_access;
  logic            cnt_last;

  assign any_access   = MemRead | MemWrite;
  assign bad_access   = any_access & ((MemRead & MemWrite) | Addr[0]);
  assign valid_access = (MemRead ^ MemWrite) & ~Addr[0] & ~Err & ~Halted;
  assign cnt_last     = (cnt == CNTW'(TIMEOUT - 1));

  // Once halted, even malformed accesses are ignored rather than flagged.
  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Halted) begin
          if (valid_access) begin
            state_d   = BUSY;
            stall_raw = 1'b1;
          end else if (bad_access) begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (mem_ready) begin
          state_d = DONE;
        end else if (cnt_last) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign Stall = stall_raw & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      MemOut    <= 16'h0000;
      Err       <= 1'b0;
      Halted    <= 1'b0;
      cnt       <= '0;
      halt_pend <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_req <= (state_d == BUSY);
      case (state_q)
        IDLE: begin
          if (state_d == BUSY) begin
            mem_addr  <= {Addr[15:1], 1'b0};
            mem_wdata <= WriteData;
            mem_wr    <= MemWrite;
            cnt       <= '0;
            halt_pend <= Halt;
          end else if (state_d == ERR) begin
            Err <= 1'b1;
          end else if (Halt && !any_access) begin
            Halted <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_wr) begin
              MemOut <= mem_rdata;
            end
          end else if (cnt_last) begin
            Err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A halt riding on an access takes effect only after that access retires.
        DONE: begin
          if (halt_pend) begin
            Halted <= 1'b1;
          end
          halt_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, timeouts, malformed accesses,
// mid-access reset and halt handling, checked through an access scoreboard.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] memOut;
  } sbEntry_t;

  logic        clk;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        Halt;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] MemOut;
  logic        Stall;
  logic        Err;
  logic        Halted;

  sbEntry_t    sbQ[$];
  logic [15:0] modelMemOut;
  int          checksTotal;
  int          checksPassed;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNTW(5)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .Halt(Halt),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .MemOut(MemOut), .Stall(Stall), .Err(Err), .Halted(Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checksTotal++;
    assert (obs === exp) checksPassed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] wdata,
                               input logic rd, input logic wr, input logic halt);
    Addr      = addr;
    WriteData = wdata;
    MemRead   = rd;
    MemWrite  = wr;
    Halt      = halt;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    modelMemOut = 16'h0000;
    sbQ.delete();
    tick();
  endtask

  // readyAt = BUSY cycle carrying mem_ready (1-based); 0 means memory never answers.
  task automatic runAccess(input logic [15:0] addr, input logic [15:0] wdata, input logic isWrite,
                           input logic halt, input int readyAt, input logic [15:0] rdata);
    sbEntry_t e;
    int nBusy;
    int reqCycles;
    int stallCycles;
    bit completes;
    completes = (readyAt >= 1 && readyAt <= TIMEOUT);
    nBusy = completes ? readyAt : TIMEOUT;
    applyStimulus(addr, wdata, !isWrite, isWrite, halt);
    if (completes && !isWrite) modelMemOut = rdata;
    e.addr = addr;
    e.wdata = wdata;
    e.wr = isWrite;
    e.memOut = modelMemOut;
    sbQ.push_back(e);
    #1;
    stallCycles = (Stall === 1'b1) ? 1 : 0;
    reqCycles = 0;
    tick();
    for (int n = 1; n <= nBusy; n++) begin
      if (n == 1) begin
        e = sbQ.pop_front();
        checkOutput("mem_addr", mem_addr, e.addr);
        checkOutput("mem_wr", {15'h0, mem_wr}, {15'h0, e.wr});
        if (e.wr) checkOutput("mem_wdata", mem_wdata, e.wdata);
      end
      if (mem_req === 1'b1) reqCycles++;
      if (Stall === 1'b1) stallCycles++;
      if (n == readyAt) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      tick();
      mem_ready = 1'b0;
      mem_rdata = 16'h0000;
    end
    checkOutput("req cycles", 16'(reqCycles), 16'(nBusy));
    checkOutput("stall cycles", 16'(stallCycles), 16'(nBusy + 1));
    checkOutput("end mem_req", {15'h0, mem_req}, 16'h0);
    checkOutput("end Stall", {15'h0, Stall}, 16'h0);
    checkOutput("end MemOut", MemOut, e.memOut);
    checkOutput("end Err", {15'h0, Err}, completes ? 16'h0 : 16'h1);
    if (completes) begin
      checkOutput("Halted in DONE", {15'h0, Halted}, 16'h0);
      applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    modelMemOut  = 16'h0000;
    mem_ready    = 1'b0;
    mem_rdata    = 16'h0000;
    rst          = 1'b0;
    applyStimulus(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset Stall", {15'h0, Stall}, 16'h0);
    checkOutput("reset mem_req", {15'h0, mem_req}, 16'h0);
    checkOutput("reset MemOut", MemOut, 16'h0000);
    checkOutput("reset Err", {15'h0, Err}, 16'h0);
    checkOutput("reset Halted", {15'h0, Halted}, 16'h0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();

    $display("[TB] load 0x0010, ready on 2nd BUSY cycle");
    runAccess(16'h0010, 16'h0000, 1'b0, 1'b0, 2, 16'hBEEF);
    $display("[TB] store 0x0020, ready on 1st BUSY cycle");
    runAccess(16'h0020, 16'h1234, 1'b1, 1'b0, 1, 16'h5A5A);

    #1;
    checkOutput("idle Stall", {15'h0, Stall}, 16'h0);
    tick();
    checkOutput("idle mem_req", {15'h0, mem_req}, 16'h0);

    $display("[TB] ready on the last allowed BUSY cycle");
    runAccess(16'h0030, 16'h0000, 1'b0, 1'b0, TIMEOUT, 16'hCAFE);
    $display("[TB] timeout with no ready");
    runAccess(16'h0040, 16'h0000, 1'b0, 1'b0, 0, 16'h0000);
    applyStimulus(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    #1;
    checkOutput("ERR ignores Stall", {15'h0, Stall}, 16'h0);
    tick();
    tick();
    mem_ready = 1'b0;
    checkOutput("ERR ignores mem_req", {15'h0, mem_req}, 16'h0);
    checkOutput("ERR holds MemOut", MemOut, 16'hCAFE);

    $display("[TB] unaligned access");
    doReset();
    applyStimulus(16'h0021, 16'h0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("unaligned Stall", {15'h0, Stall}, 16'h0);
    tick();
    checkOutput("unaligned Err", {15'h0, Err}, 16'h1);
    checkOutput("unaligned mem_req", {15'h0, mem_req}, 16'h0);
    applyStimulus(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("after-err load mem_req", {15'h0, mem_req}, 16'h0);

    $display("[TB] read and write together");
    doReset();
    applyStimulus(16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("rd+wr Err", {15'h0, Err}, 16'h1);
    checkOutput("rd+wr mem_req", {15'h0, mem_req}, 16'h0);

    $display("[TB] reset on 3rd BUSY cycle");
    doReset();
    applyStimulus(16'h0050, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("pre-reset mem_req", {15'h0, mem_req}, 16'h1);
    rst = 1'b0;
    #1;
    checkOutput("in-reset Stall", {15'h0, Stall}, 16'h0);
    tick();
    checkOutput("mid reset mem_req", {15'h0, mem_req}, 16'h0);
    checkOutput("mid reset mem_addr", mem_addr, 16'h0000);
    checkOutput("mid reset Err", {15'h0, Err}, 16'h0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    mem_ready = 1'b1;
    mem_rdata = 16'h5555;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    checkOutput("late ready MemOut", MemOut, 16'h0000);
    checkOutput("late ready mem_req", {15'h0, mem_req}, 16'h0);

    $display("[TB] halt with load");
    runAccess(16'h0060, 16'h0000, 1'b0, 1'b1, 1, 16'h7777);
    checkOutput("Halted after DONE", {15'h0, Halted}, 16'h1);
    applyStimulus(16'h0070, 16'h0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("halted Stall", {15'h0, Stall}, 16'h0);
    tick();
    tick();
    checkOutput("halted mem_req", {15'h0, mem_req}, 16'h0);
    checkOutput("halted MemOut", MemOut, 16'h7777);

    $display("[TB] halt alone");
    doReset();
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("halt-only Stall", {15'h0, Stall}, 16'h0);
    tick();
    checkOutput("halt-only Halted", {15'h0, Halted}, 16'h1);
    checkOutput("halt-only mem_req", {15'h0, mem_req}, 16'h0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
